// File: rtl/packet_buffer_pkg.sv
// Shared types and limits for the lane packet buffer.
// Packets are a 2-byte big-endian length header followed by the payload bytes.
package packet_buffer_pkg;

  localparam int MAX_PACKET_LENGTH = 1518;
  localparam int LEN_HDR_BYTES     = 2;
  localparam int PKT_LEN_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    PAYLOAD = 3'd3,
    DISCARD = 3'd4
  } gather_state_e;

endpackage

// File: rtl/lane_rr_arbiter.sv
// Combinational round-robin pick: the first requesting lane after ptr (mod NUM_LANES).
module lane_rr_arbiter #(
  parameter int NUM_LANES = 8,
  parameter int SEL_W     = 3
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     grant,
  output logic                 any_req
);

  // Scan from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (req[SEL_W'((int'(ptr) + k) % NUM_LANES)]) begin
        grant   = SEL_W'((int'(ptr) + k) % NUM_LANES);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_lane_gather.sv
// Drains one whole length-prefixed packet at a time from a chosen byte lane and
// repacks its payload into AXI4-Stream beats (first byte in the LSB lane).
module packet_lane_gather #(
  parameter int AXI_WIDTH          = 64,
  parameter int LANE_WIDTH         = 8,
  parameter int MAX_PACKET_LENGTH  = packet_buffer_pkg::MAX_PACKET_LENGTH,
  localparam int NUM_LANES         = AXI_WIDTH / LANE_WIDTH,
  localparam int BYTES_PER_BEAT    = AXI_WIDTH / 8,
  localparam int SEL_W             = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] lane_tdata_i,
  input  logic [NUM_LANES-1:0]            lane_tvalid_i,
  output logic [NUM_LANES-1:0]            lane_tready_o,
  output logic [AXI_WIDTH-1:0]            tdata_o,
  output logic [BYTES_PER_BEAT-1:0]       tkeep_o,
  output logic                            tlast_o,
  output logic                            tvalid_o,
  input  logic                            tready_i,
  output logic [SEL_W-1:0]                lane_sel_o,
  output logic                            len_err_o,
  output logic [2:0]                      state_o
);

  import packet_buffer_pkg::*;

  localparam int CNT_W = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;
  localparam logic [PKT_LEN_WIDTH-1:0] MAX_LEN = PKT_LEN_WIDTH'(MAX_PACKET_LENGTH);

  gather_state_e state, state_next;

  logic [SEL_W-1:0]          ptr;
  logic [SEL_W-1:0]          grant;
  logic                      any_req;
  logic [LANE_WIDTH-1:0]     len_hi;
  logic [PKT_LEN_WIDTH-1:0]  remaining;
  logic [PKT_LEN_WIDTH-1:0]  hdr_len;
  logic [CNT_W-1:0]          cnt;
  logic [AXI_WIDTH-1:0]      acc;
  logic [AXI_WIDTH-1:0]      beat_word;
  logic [BYTES_PER_BEAT-1:0] beat_keep;
  logic [LANE_WIDTH-1:0]     cur_byte;
  logic                      cur_valid;
  logic                      closing;
  logic                      out_free;
  logic                      sel_ready;
  logic                      xfer;

  lane_rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .SEL_W     (SEL_W)
  ) u_arb (
    .req     (lane_tvalid_i),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign state_o   = state;
  assign cur_byte  = lane_tdata_i[int'(lane_sel_o)*LANE_WIDTH +: LANE_WIDTH];
  assign cur_valid = lane_tvalid_i[lane_sel_o];
  assign hdr_len   = PKT_LEN_WIDTH'({len_hi, cur_byte});
  assign closing   = (cnt == CNT_W'(BYTES_PER_BEAT - 1)) || (remaining == 1);
  assign out_free  = !tvalid_o || tready_i;

  // Handshakes: a lane byte moves when lane_tvalid_i[i] && lane_tready_o[i]; an
  // output beat moves when tvalid_o && tready_i. A closing byte is only accepted
  // when the output register is free or draining this same cycle.
  assign sel_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DISCARD) ||
                     ((state == PAYLOAD) && (!closing || out_free));
  assign xfer      = cur_valid && sel_ready;

  always_comb begin
    lane_tready_o             = '0;
    lane_tready_o[lane_sel_o] = sel_ready;
  end

  always_comb begin
    beat_word = acc;
    beat_word[int'(cnt)*LANE_WIDTH +: LANE_WIDTH] = cur_byte;
    beat_keep = '0;
    for (int k = 0; k < BYTES_PER_BEAT; k++) begin
      beat_keep[k] = (k <= int'(cnt));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = HDR_HI;
      HDR_HI:  if (xfer) state_next = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (hdr_len == '0)          state_next = IDLE;
          else if (hdr_len > MAX_LEN) state_next = DISCARD;
          else                        state_next = PAYLOAD;
        end
      end
      PAYLOAD: if (xfer && remaining == 1) state_next = IDLE;
      DISCARD: if (xfer && remaining == 1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr        <= SEL_W'(NUM_LANES - 1);
      lane_sel_o <= '0;
      len_hi     <= '0;
      remaining  <= '0;
      cnt        <= '0;
      acc        <= '0;
      tdata_o    <= '0;
      tkeep_o    <= '0;
      tlast_o    <= 1'b0;
      tvalid_o   <= 1'b0;
      len_err_o  <= 1'b0;
    end else begin
      len_err_o <= 1'b0;
      if (tvalid_o && tready_i) tvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            lane_sel_o <= grant;
            ptr        <= grant;
          end
        end
        HDR_HI: if (xfer) len_hi <= cur_byte;
        HDR_LO: begin
          if (xfer) begin
            remaining <= hdr_len;
            cnt       <= '0;
            acc       <= '0;
            if (hdr_len > MAX_LEN) len_err_o <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (closing) begin
              // A load here overrides the drain above, so close+drain has no bubble.
              tdata_o  <= beat_word;
              tkeep_o  <= beat_keep;
              tlast_o  <= (remaining == 1);
              tvalid_o <= 1'b1;
              cnt      <= '0;
              acc      <= '0;
            end else begin
              acc <= beat_word;
              cnt <= cnt + 1'b1;
            end
          end
        end
        DISCARD: if (xfer) remaining <= remaining - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
